bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 104 ++++++++++
 tb/tb_bin2bcd_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one input bit per clock.
// Latency: done pulses BIN_W clocks after the accepting edge; one result per BIN_W+1 clocks back-to-back.
// Backpressure: start is ignored while busy=1 (no queueing); start during the done cycle is accepted.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, bin     conversion request and unsigned operand, sampled only when busy=0
//   busy           conversion in progress
//   done           one-cycle pulse when bcd/overflow update
//   bcd            packed BCD result, digit 0 (units) in bits [3:0]
//   overflow       last result exceeded 10^DIGITS-1
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int SAT    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [BIN_W-1:0]  shreg;
  logic [BCD_W-1:0]  scratch;
  logic              sticky;
  logic [CNT_W-1:0]  cnt;

  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  scratch_nxt;
  logic [BIN_W-1:0]  shreg_nxt;
  logic              sticky_nxt;

  // One double-dabble iteration: per-digit add-3 correction, then shift the
  // combined {scratch, shreg} left so the binary MSB enters digit 0. Digits
  // never carry into each other; the bit falling off the top digit can only
  // be set when the value no longer fits in DIGITS digits.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                   : scratch[4*i +: 4];
    end
    {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
    sticky_nxt = sticky | adj[BCD_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      sticky   <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg_nxt;
          scratch <= scratch_nxt;
          sticky  <= sticky_nxt;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            if (SAT != 0 && sticky_nxt) begin
              bcd <= {DIGITS{4'h9}};
            end else begin
              bcd <= scratch_nxt;
            end
            overflow <= sticky_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Five configurations: 0:(14,4,wrap) 1:(14,4,sat) 2:(14,5,wrap) 3:(1,1,wrap) 4:(8,2,wrap)
  int W [5] = '{14, 14, 14, 1, 8};
  int D [5] = '{4, 4, 5, 1, 2};
  int S [5] = '{0, 1, 0, 0, 0};

  logic [4:0]  start_a = '0;
  logic [31:0] bin_a [5];

  logic        d0_busy, d1_busy, d2_busy, d3_busy, d4_busy;
  logic        d0_done, d1_done, d2_done, d3_done, d4_done;
  logic        d0_ov, d1_ov, d2_ov, d3_ov, d4_ov;
  logic [15:0] d0_bcd, d1_bcd;
  logic [19:0] d2_bcd;
  logic [3:0]  d3_bcd;
  logic [7:0]  d4_bcd;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .SAT(0)) d0 (.clk(clk), .rst_n(rst_n), .start(start_a[0]),
    .bin(bin_a[0][13:0]), .busy(d0_busy), .done(d0_done), .bcd(d0_bcd), .overflow(d0_ov));
  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .SAT(1)) d1 (.clk(clk), .rst_n(rst_n), .start(start_a[1]),
    .bin(bin_a[1][13:0]), .busy(d1_busy), .done(d1_done), .bcd(d1_bcd), .overflow(d1_ov));
  bin2bcd_seq #(.BIN_W(14), .DIGITS(5), .SAT(0)) d2 (.clk(clk), .rst_n(rst_n), .start(start_a[2]),
    .bin(bin_a[2][13:0]), .busy(d2_busy), .done(d2_done), .bcd(d2_bcd), .overflow(d2_ov));
  bin2bcd_seq #(.BIN_W(1), .DIGITS(1), .SAT(0)) d3 (.clk(clk), .rst_n(rst_n), .start(start_a[3]),
    .bin(bin_a[3][0:0]), .busy(d3_busy), .done(d3_done), .bcd(d3_bcd), .overflow(d3_ov));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SAT(0)) d4 (.clk(clk), .rst_n(rst_n), .start(start_a[4]),
    .bin(bin_a[4][7:0]), .busy(d4_busy), .done(d4_done), .bcd(d4_bcd), .overflow(d4_ov));

  logic [4:0]  busy_v, done_v, ov_v;
  logic [63:0] ob [5];
  assign busy_v = {d4_busy, d3_busy, d2_busy, d1_busy, d0_busy};
  assign done_v = {d4_done, d3_done, d2_done, d1_done, d0_done};
  assign ov_v   = {d4_ov, d3_ov, d2_ov, d1_ov, d0_ov};
  assign ob[0]  = 64'(d0_bcd);
  assign ob[1]  = 64'(d1_bcd);
  assign ob[2]  = 64'(d2_bcd);
  assign ob[3]  = 64'(d3_bcd);
  assign ob[4]  = 64'(d4_bcd);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion from plain decimal arithmetic.
  function automatic longint pow10(input int d);
    longint p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [63:0] ref_bcd(input longint v, input int d, input int s);
    logic [63:0] r = '0;
    longint x;
    if (s != 0 && v >= pow10(d)) begin
      for (int k = 0; k < d; k++) r[4*k +: 4] = 4'h9;
    end else begin
      x = v % pow10(d);
      for (int k = 0; k < d; k++) begin
        r[4*k +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // Transaction-level model: accept when idle, report the converted value
  // W edges later, hold results until the next completion.
  logic        m_busy [5];
  logic        m_done [5];
  logic        m_ov   [5];
  logic [63:0] m_bcd  [5];
  int          m_left [5];
  longint      m_val  [5];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 5; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_ov[i] <= 1'b0;
        m_bcd[i]  <= '0;   m_left[i] <= 0;    m_val[i] <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (start_a[i]) begin
            m_busy[i] <= 1'b1;
            m_left[i] <= W[i];
            m_val[i]  <= longint'(bin_a[i]) & ((longint'(1) << W[i]) - 1);
          end
        end else if (m_left[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_bcd[i]  <= ref_bcd(m_val[i], D[i], S[i]);
          m_ov[i]   <= (m_val[i] >= pow10(D[i]));
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  logic checking = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("busy[%0d]", i), longint'(busy_v[i]), longint'(m_busy[i]));
        chk($sformatf("done[%0d]", i), longint'(done_v[i]), longint'(m_done[i]));
        chk($sformatf("bcd[%0d]", i),  longint'(ob[i]),     longint'(m_bcd[i]));
        chk($sformatf("ovf[%0d]", i),  longint'(ov_v[i]),   longint'(m_ov[i]));
      end
    end
  end

  // All tasks are entered just after a falling edge.
  task automatic start_pulse(input int i, input longint v);
    bin_a[i]   = 32'(v);
    start_a[i] = 1'b1;
    @(negedge clk);
    start_a[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done_v[i] && c < 200);
    if (!done_v[i]) begin
      bad++;
      total++;
      $display("FAIL timeout[%0d]: no done after %0d cycles", i, c);
    end
  endtask

  task automatic run(input int i, input longint v, input longint eb, input longint eo, input string nm);
    int c;
    start_pulse(i, v);
    wait_done(i, c);
    chk({nm, "_lat"}, c, W[i]);
    chk({nm, "_bcd"}, longint'(ob[i]), eb);
    chk({nm, "_ovf"}, longint'(ov_v[i]), eo);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int ndone;
    longint v;
    for (int i = 0; i < 5; i++) bin_a[i] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_busy", longint'(d0_busy), 0);
    chk("rst_done", longint'(d0_done), 0);
    chk("rst_bcd",  longint'(d0_bcd), 0);
    chk("rst_ovf",  longint'(d0_ov), 0);

    run(0, 9999,  'h9999, 0, "w9999");
    run(0, 0,     'h0000, 0, "w0");
    run(0, 10000, 'h0000, 1, "w10000");
    run(0, 16383, 'h6383, 1, "w16383");
    run(1, 10000, 'h9999, 1, "s10000");
    run(1, 16383, 'h9999, 1, "s16383");

    // Second start while busy is dropped; a start in the done cycle is taken.
    start_pulse(0, 1234);
    repeat (4) @(negedge clk);
    start_pulse(0, 42);
    wait_done(0, c);
    chk("ign_lat", c, 9);
    chk("ign_bcd", longint'(d0_bcd), 'h1234);
    start_pulse(0, 42);
    wait_done(0, c);
    chk("b2b_lat", c, 14);
    chk("b2b_bcd", longint'(d0_bcd), 'h0042);

    // Reset in the middle of iteration 7.
    start_pulse(0, 5678);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", longint'(d0_busy), 0);
    chk("arst_done", longint'(d0_done), 0);
    chk("arst_bcd",  longint'(d0_bcd), 0);
    chk("arst_ovf",  longint'(d0_ov), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (d0_done) ndone++;
    end
    chk("arst_nodone", ndone, 0);
    run(0, 5678, 'h5678, 0, "w5678");

    // Start held high: streaming conversions, one result every 15 cycles.
    bin_a[2] = 0;
    start_a[2] = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      wait_done(2, c);
      chk("stream_gap", c, 15);
      v = (k + 1 < 2000) ? longint'(k + 1) : longint'(14384 + (k + 1 - 2000));
      bin_a[2] = 32'(v);
      if (k == 3999) start_a[2] = 1'b0;
    end
    chk("stream_last_bcd", longint'(d2_bcd), 'h16383);
    chk("stream_last_ovf", longint'(d2_ov), 0);
    repeat (20) @(negedge clk);

    run(3, 1,   'h1,  0, "w1b");
    run(3, 0,   'h0,  0, "w1b0");
    run(4, 255, 'h55, 1, "w8b255");
    run(4, 99,  'h99, 0, "w8b99");
    repeat (3) @(negedge clk);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
